// File: rtl/contextual_encoder.sv
// Conditional encoder: frame + multi-scale contexts -> latent, 8 register stages, free-running.
// Every stage output is saturated to the element range; residual paths are delayed one stage to align.
module contextual_encoder_conv #(
  parameter int DW   = 8,
  parameter int B    = 1,
  parameter int CIN  = 1,
  parameter int COUT = 1,
  parameter int HI   = 16,
  parameter int WI   = 16,
  parameter int K    = 3,
  parameter int S    = 2,
  parameter int PAD  = 1,
  parameter int RELU = 0,
  parameter int RES  = 0,
  parameter int HO   = HI / S,
  parameter int WO   = WI / S
) (
  input  logic [B*CIN*HI*WI*DW-1:0]  in_dat,
  input  logic [COUT*CIN*K*K*DW-1:0] w_dat,
  input  logic [COUT*DW-1:0]         b_dat,
  input  logic [B*COUT*HO*WO*DW-1:0] res_dat,
  output logic [B*COUT*HO*WO*DW-1:0] out_dat
);
  localparam logic signed [31:0] SMAX = (32'sd1 <<< (DW - 1)) - 32'sd1;
  localparam logic signed [31:0] SMIN = -(32'sd1 <<< (DW - 1));

  logic signed [31:0] acc;
  int iy, ix, ii, wi, oi;

  always_comb begin
    out_dat = '0;
    acc = '0;
    iy = 0;
    ix = 0;
    ii = 0;
    wi = 0;
    oi = 0;
    for (int b = 0; b < B; b++) begin
      for (int o = 0; o < COUT; o++) begin
        for (int oy = 0; oy < HO; oy++) begin
          for (int ox = 0; ox < WO; ox++) begin
            acc = 32'($signed(b_dat[o*DW +: DW]));
            for (int i = 0; i < CIN; i++) begin
              for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                  // Tap window is centred on (oy*S, ox*S); padding reads as zero.
                  iy = oy * S + ky - PAD;
                  ix = ox * S + kx - PAD;
                  if (iy >= 0 && iy < HI && ix >= 0 && ix < WI) begin
                    ii = ((b * CIN + i) * HI + iy) * WI + ix;
                    wi = ((o * CIN + i) * K + ky) * K + kx;
                    acc = acc + 32'($signed(in_dat[ii*DW +: DW])) * 32'($signed(w_dat[wi*DW +: DW]));
                  end
                end
              end
            end
            oi = ((b * COUT + o) * HO + oy) * WO + ox;
            if (RES != 0) acc = acc + 32'($signed(res_dat[oi*DW +: DW]));
            if (RELU != 0 && acc < 0) acc = '0;
            if (acc > SMAX) acc = SMAX;
            else if (acc < SMIN) acc = SMIN;
            out_dat[oi*DW +: DW] = acc[DW-1:0];
          end
        end
      end
    end
  end
endmodule

module contextual_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int BATCH_SIZE  = 1,
  parameter int CHANNEL_N   = 1,
  parameter int CHANNEL_M   = 1,
  parameter int HEIGHT      = 16,
  parameter int WIDTH       = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 2,
  parameter int PADDING     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [BATCH_SIZE*CHANNEL_N*HEIGHT*WIDTH*DATA_WIDTH-1:0]         x,
  input  logic [BATCH_SIZE*3*HEIGHT*WIDTH*DATA_WIDTH-1:0]                 context1,
  input  logic [BATCH_SIZE*CHANNEL_N*(HEIGHT/2)*(WIDTH/2)*DATA_WIDTH-1:0] context2,
  input  logic [BATCH_SIZE*CHANNEL_N*(HEIGHT/4)*(WIDTH/4)*DATA_WIDTH-1:0] context3,
  input  logic [CHANNEL_N*(CHANNEL_N+3)*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] conv1_weights,
  input  logic [CHANNEL_N*DATA_WIDTH-1:0]                                       conv1_bias,
  input  logic [CHANNEL_N*2*CHANNEL_N*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   conv2_weights,
  input  logic [CHANNEL_N*DATA_WIDTH-1:0]                                       conv2_bias,
  input  logic [CHANNEL_N*2*CHANNEL_N*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   conv3_weights,
  input  logic [CHANNEL_N*DATA_WIDTH-1:0]                                       conv3_bias,
  input  logic [CHANNEL_M*CHANNEL_N*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     conv4_weights,
  input  logic [CHANNEL_M*DATA_WIDTH-1:0]                                       conv4_bias,
  input  logic [CHANNEL_N*2*CHANNEL_N*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   res1_weights1,
  input  logic [CHANNEL_N*DATA_WIDTH-1:0]                                       res1_bias1,
  input  logic [2*CHANNEL_N*CHANNEL_N*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   res1_weights2,
  input  logic [2*CHANNEL_N*DATA_WIDTH-1:0]                                     res1_bias2,
  input  logic [CHANNEL_N*2*CHANNEL_N*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   res2_weights1,
  input  logic [CHANNEL_N*DATA_WIDTH-1:0]                                       res2_bias1,
  input  logic [2*CHANNEL_N*CHANNEL_N*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   res2_weights2,
  input  logic [2*CHANNEL_N*DATA_WIDTH-1:0]                                     res2_bias2,
  output logic [BATCH_SIZE*CHANNEL_M*(HEIGHT/16)*(WIDTH/16)*DATA_WIDTH-1:0] feature_out
);
  localparam int DW  = DATA_WIDTH;
  localparam int B   = BATCH_SIZE;
  localparam int N   = CHANNEL_N;
  localparam int M   = CHANNEL_M;
  localparam int K   = KERNEL_SIZE;
  localparam int H   = HEIGHT;
  localparam int W   = WIDTH;
  localparam int A1  = H * W;
  localparam int A2  = (H / 2) * (W / 2);
  localparam int A4  = (H / 4) * (W / 4);
  localparam int A8  = (H / 8) * (W / 8);
  localparam int A16 = (H / 16) * (W / 16);

  logic [B*(N+3)*A1*DW-1:0] cat0;
  logic [B*N*A2*DW-1:0]     s1_d, s1_q, t1_d, t1_q;
  logic [B*2*N*A2*DW-1:0]   cat1, res1_d, res1_q, r1_d, r1_q;
  logic [B*N*A4*DW-1:0]     s4_d, s4_q, t2_d, t2_q;
  logic [B*2*N*A4*DW-1:0]   cat2, res2_d, res2_q, r2_d, r2_q;
  logic [B*N*A8*DW-1:0]     s7_d, s7_q;
  logic [B*M*A16*DW-1:0]    feature_out_d, feature_out_q;

  // Channel concat per image: first operand takes the low channel indices.
  for (genvar gb = 0; gb < B; gb++) begin : g_cat
    assign cat0[gb*(N+3)*A1*DW +: N*A1*DW]     = x[gb*N*A1*DW +: N*A1*DW];
    assign cat0[(gb*(N+3)+N)*A1*DW +: 3*A1*DW] = context1[gb*3*A1*DW +: 3*A1*DW];
    assign cat1[gb*2*N*A2*DW +: N*A2*DW]       = s1_q[gb*N*A2*DW +: N*A2*DW];
    assign cat1[(gb*2*N+N)*A2*DW +: N*A2*DW]   = context2[gb*N*A2*DW +: N*A2*DW];
    assign cat2[gb*2*N*A4*DW +: N*A4*DW]       = s4_q[gb*N*A4*DW +: N*A4*DW];
    assign cat2[(gb*2*N+N)*A4*DW +: N*A4*DW]   = context3[gb*N*A4*DW +: N*A4*DW];
  end

  // Skip connections ride one stage alongside the first res conv.
  always_comb begin
    res1_d = cat1;
    res2_d = cat2;
  end

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(N+3), .COUT(N), .HI(H), .WI(W), .K(K),
    .S(STRIDE), .PAD(PADDING), .RELU(0), .RES(0)) u_conv1 (
    .in_dat(cat0), .w_dat(conv1_weights), .b_dat(conv1_bias), .res_dat('0), .out_dat(s1_d));

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(2*N), .COUT(N), .HI(H/2), .WI(W/2), .K(K),
    .S(1), .PAD(PADDING), .RELU(1), .RES(0)) u_res1a (
    .in_dat(cat1), .w_dat(res1_weights1), .b_dat(res1_bias1), .res_dat('0), .out_dat(t1_d));

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(N), .COUT(2*N), .HI(H/2), .WI(W/2), .K(K),
    .S(1), .PAD(PADDING), .RELU(0), .RES(1)) u_res1b (
    .in_dat(t1_q), .w_dat(res1_weights2), .b_dat(res1_bias2), .res_dat(res1_q), .out_dat(r1_d));

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(2*N), .COUT(N), .HI(H/2), .WI(W/2), .K(K),
    .S(STRIDE), .PAD(PADDING), .RELU(0), .RES(0)) u_conv2 (
    .in_dat(r1_q), .w_dat(conv2_weights), .b_dat(conv2_bias), .res_dat('0), .out_dat(s4_d));

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(2*N), .COUT(N), .HI(H/4), .WI(W/4), .K(K),
    .S(1), .PAD(PADDING), .RELU(1), .RES(0)) u_res2a (
    .in_dat(cat2), .w_dat(res2_weights1), .b_dat(res2_bias1), .res_dat('0), .out_dat(t2_d));

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(N), .COUT(2*N), .HI(H/4), .WI(W/4), .K(K),
    .S(1), .PAD(PADDING), .RELU(0), .RES(1)) u_res2b (
    .in_dat(t2_q), .w_dat(res2_weights2), .b_dat(res2_bias2), .res_dat(res2_q), .out_dat(r2_d));

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(2*N), .COUT(N), .HI(H/4), .WI(W/4), .K(K),
    .S(STRIDE), .PAD(PADDING), .RELU(0), .RES(0)) u_conv3 (
    .in_dat(r2_q), .w_dat(conv3_weights), .b_dat(conv3_bias), .res_dat('0), .out_dat(s7_d));

  contextual_encoder_conv #(.DW(DW), .B(B), .CIN(N), .COUT(M), .HI(H/8), .WI(W/8), .K(K),
    .S(STRIDE), .PAD(PADDING), .RELU(0), .RES(0)) u_conv4 (
    .in_dat(s7_q), .w_dat(conv4_weights), .b_dat(conv4_bias), .res_dat('0), .out_dat(feature_out_d));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q          <= '0;
      t1_q          <= '0;
      res1_q        <= '0;
      r1_q          <= '0;
      s4_q          <= '0;
      t2_q          <= '0;
      res2_q        <= '0;
      r2_q          <= '0;
      s7_q          <= '0;
      feature_out_q <= '0;
    end else begin
      s1_q          <= s1_d;
      t1_q          <= t1_d;
      res1_q        <= res1_d;
      r1_q          <= r1_d;
      s4_q          <= s4_d;
      t2_q          <= t2_d;
      res2_q        <= res2_d;
      r2_q          <= r2_d;
      s7_q          <= s7_d;
      feature_out_q <= feature_out_d;
    end
  end

  assign feature_out = feature_out_q;
endmodule

// File: tb/tb_contextual_encoder.sv
// Directed bench for contextual_encoder: expected values queued at stimulus time, popped at check points.
module tb_contextual_encoder;
  localparam int DW = 8;
  localparam int N  = 1;
  localparam int M  = 1;
  localparam int H  = 16;
  localparam int W  = 16;
  localparam int KK = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*H*W*DW-1:0]           x;
  logic [3*H*W*DW-1:0]           context1;
  logic [N*(H/2)*(W/2)*DW-1:0]   context2;
  logic [N*(H/4)*(W/4)*DW-1:0]   context3;
  logic [N*(N+3)*KK*DW-1:0]      conv1_weights;
  logic [N*DW-1:0]               conv1_bias;
  logic [N*2*N*KK*DW-1:0]        conv2_weights;
  logic [N*DW-1:0]               conv2_bias;
  logic [N*2*N*KK*DW-1:0]        conv3_weights;
  logic [N*DW-1:0]               conv3_bias;
  logic [M*N*KK*DW-1:0]          conv4_weights;
  logic [M*DW-1:0]               conv4_bias;
  logic [N*2*N*KK*DW-1:0]        res1_weights1;
  logic [N*DW-1:0]               res1_bias1;
  logic [2*N*N*KK*DW-1:0]        res1_weights2;
  logic [2*N*DW-1:0]             res1_bias2;
  logic [N*2*N*KK*DW-1:0]        res2_weights1;
  logic [N*DW-1:0]               res2_bias1;
  logic [2*N*N*KK*DW-1:0]        res2_weights2;
  logic [2*N*DW-1:0]             res2_bias2;
  logic [M*DW-1:0]               feature_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  contextual_encoder dut (
    .clk(clk), .rst(rst), .x(x), .context1(context1), .context2(context2), .context3(context3),
    .conv1_weights(conv1_weights), .conv1_bias(conv1_bias),
    .conv2_weights(conv2_weights), .conv2_bias(conv2_bias),
    .conv3_weights(conv3_weights), .conv3_bias(conv3_bias),
    .conv4_weights(conv4_weights), .conv4_bias(conv4_bias),
    .res1_weights1(res1_weights1), .res1_bias1(res1_bias1),
    .res1_weights2(res1_weights2), .res1_bias2(res1_bias2),
    .res2_weights1(res2_weights1), .res2_bias1(res2_bias1),
    .res2_weights2(res2_weights2), .res2_bias2(res2_bias2),
    .feature_out(feature_out));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but scoreboard is empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic zero_all();
    x = '0; context1 = '0; context2 = '0; context3 = '0;
    conv1_weights = '0; conv1_bias = '0; conv2_weights = '0; conv2_bias = '0;
    conv3_weights = '0; conv3_bias = '0; conv4_weights = '0; conv4_bias = '0;
    res1_weights1 = '0; res1_bias1 = '0; res1_weights2 = '0; res1_bias2 = '0;
    res2_weights1 = '0; res2_bias1 = '0; res2_weights2 = '0; res2_bias2 = '0;
  endtask

  task automatic all_weights_one();
    conv1_weights = {(N*(N+3)*KK){8'h01}};
    conv2_weights = {(2*N*N*KK){8'h01}};
    conv3_weights = {(2*N*N*KK){8'h01}};
    conv4_weights = {(M*N*KK){8'h01}};
    res1_weights1 = {(2*N*N*KK){8'h01}};
    res1_weights2 = {(2*N*N*KK){8'h01}};
    res2_weights1 = {(2*N*N*KK){8'h01}};
    res2_weights2 = {(2*N*N*KK){8'h01}};
  endtask

  task automatic case4_inputs();
    zero_all();
    x        = {(N*H*W){8'h01}};
    context1 = {(3*H*W){8'h02}};
    context2 = {(N*(H/2)*(W/2)){8'h03}};
    context3 = {(N*(H/4)*(W/4)){8'h04}};
    all_weights_one();
  endtask

  initial begin
    zero_all();
    rst = 1'b0;
    #1;
    expect_val(8'h00);
    check("reset_state", feature_out);
    tick(2);
    rst = 1'b1;

    // Bias-only paths through the final conv.
    conv4_bias = 8'h05;
    expect_val(8'h05);
    tick(8);
    check("bias_pos", feature_out);

    conv4_bias = 8'hFB;
    expect_val(8'hFB);
    tick(8);
    check("bias_neg", feature_out);

    // Negative first res conv must be clamped; without the clamp -128 would propagate.
    zero_all();
    res1_bias1    = 8'h80;
    res1_weights2 = {(2*N*N*KK){8'h01}};
    conv2_weights = {(2*N*N*KK){8'h01}};
    conv3_weights = {(2*N*N*KK){8'h01}};
    conv4_weights = {(M*N*KK){8'h01}};
    conv4_bias    = 8'h05;
    expect_val(8'h05);
    tick(8);
    check("relu_clamp", feature_out);

    // Saturating case plus first-stage border values.
    case4_inputs();
    expect_val(8'h7F);
    expect_val(8'd28);
    expect_val(8'd42);
    expect_val(8'd63);
    tick(8);
    check("sat_out", feature_out);
    check("s1_corner", dut.s1_q[7:0]);
    check("s1_edge", dut.s1_q[15:8]);
    check("s1_interior", dut.s1_q[79:72]);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    rst = 1'b0;
    expect_val(8'h00);
    #1;
    check("async_rst", feature_out);
    expect_val(8'h00);
    expect_val(8'h00);
    tick(3);
    check("rst_hold", feature_out);
    check("rst_hold_s1", dut.s1_q[79:72]);
    rst = 1'b1;

    // Mid-stream reset discards in-flight data.
    tick(4);
    rst = 1'b0;
    expect_val(8'h00);
    #1;
    check("midstream_rst", feature_out);
    rst = 1'b1;
    expect_val(8'h7F);
    tick(8);
    check("after_rst_8", feature_out);

    // Latency: only x drives the pipe, so nothing reaches the output before edge 8.
    zero_all();
    all_weights_one();
    x = {(N*H*W){8'h01}};
    rst = 1'b0;
    #2;
    rst = 1'b1;
    expect_val(8'd4);
    expect_val(8'd9);
    expect_val(8'h00);
    expect_val(8'h7F);
    tick(1);
    check("x_only_s1_corner", dut.s1_q[7:0]);
    check("x_only_s1_interior", dut.s1_q[79:72]);
    tick(6);
    check("latency_edge7", feature_out);
    tick(1);
    check("latency_edge8", feature_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule
